// File: rtl/ram_access_arbiter_if.sv
// ram_access_arbiter_if: user, scan and RAM signals of the RAM access arbiter.
//   tick, clear_req           scan-step strobe and zero-fill restart pulse
//   wr_req/addr/data, wr_ack  user write port (level request, one-cycle ack)
//   rd_req/addr, rd_ack       user read port (level request, one-cycle ack)
//   rd_data, rd_valid         user read result
//   scan_addr/data/valid      auto-scan result
//   scan_wrap, scan_ovf       scan wrap toggle and sticky overflow flag
//   busy                      zero-fill in progress
//   ram_addr/data/wren, ram_q single-port RAM bus
// Modport slave is the arbiter side; master is the environment side.
interface ram_access_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 4
);
    logic              tick;
    logic              clear_req;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W-1:0] scan_addr;
    logic [DATA_W-1:0] scan_data;
    logic              scan_valid;
    logic              scan_wrap;
    logic              scan_ovf;
    logic              busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  tick, clear_req, wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_q,
        output wr_ack, rd_ack, rd_data, rd_valid, scan_addr, scan_data, scan_valid,
               scan_wrap, scan_ovf, busy, ram_addr, ram_data, ram_wren
    );

    modport master (
        output tick, clear_req, wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_q,
        input  wr_ack, rd_ack, rd_data, rd_valid, scan_addr, scan_data, scan_valid,
               scan_wrap, scan_ovf, busy, ram_addr, ram_data, ram_wren
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: sequences every access to a single-port 2**ADDR_W x DATA_W RAM.
// After reset or clear_req the whole RAM is zero-filled (busy=1), then one access per
// cycle is granted with fixed priority: user write > user read > pending scan read.
// Ports:
//   i_clk    system clock
//   i_reset  synchronous active-high reset
//   bus      ram_access_arbiter_if slave modport (user ports, scan outputs, RAM bus)
// Grants and acks are decided combinationally in the cycle the access is issued; read
// results come back through a tag pipeline and are registered on the way out.
module ram_access_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    ram_access_arbiter_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic {StInit, StRun} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_fill_cnt;
    logic [ADDR_W-1:0] r_scan_ptr;
    logic              r_scan_pending;
    logic [ADDR_W-1:0] r_last_addr;

    // Read-tag pipeline: stage RD_LAT-1 lines up with valid ram_q.
    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_scan;
    logic [ADDR_W-1:0] r_tag_addr [RD_LAT];

    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic [ADDR_W-1:0] r_scan_addr;
    logic [DATA_W-1:0] r_scan_data;
    logic              r_scan_valid;
    logic              r_scan_wrap;
    logic              r_scan_ovf;

    logic              w_grant_wr;
    logic              w_grant_rd;
    logic              w_grant_scan;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_data;
    logic              w_ram_wren;

    // No grants while clearing, so nothing is issued that would only be flushed.
    always_comb begin
        w_grant_wr   = 1'b0;
        w_grant_rd   = 1'b0;
        w_grant_scan = 1'b0;
        if (r_state == StRun && !bus.clear_req) begin
            if (bus.wr_req) begin
                w_grant_wr = 1'b1;
            end else if (bus.rd_req) begin
                w_grant_rd = 1'b1;
            end else if (r_scan_pending) begin
                w_grant_scan = 1'b1;
            end
        end
    end

    always_comb begin
        w_ram_addr = r_last_addr;
        w_ram_data = '0;
        w_ram_wren = 1'b0;
        if (r_state == StInit) begin
            w_ram_addr = r_fill_cnt;
            w_ram_wren = 1'b1;
        end else if (w_grant_wr) begin
            w_ram_addr = bus.wr_addr;
            w_ram_data = bus.wr_data;
            w_ram_wren = 1'b1;
        end else if (w_grant_rd) begin
            w_ram_addr = bus.rd_addr;
        end else if (w_grant_scan) begin
            w_ram_addr = r_scan_ptr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= StInit;
            r_fill_cnt     <= '0;
            r_scan_ptr     <= '0;
            r_scan_pending <= 1'b0;
            r_last_addr    <= '0;
            r_tag_vld      <= '0;
            r_tag_scan     <= '0;
            r_rd_data      <= '0;
            r_rd_valid     <= 1'b0;
            r_scan_addr    <= '0;
            r_scan_data    <= '0;
            r_scan_valid   <= 1'b0;
            r_scan_wrap    <= 1'b0;
            r_scan_ovf     <= 1'b0;
        end else begin
            r_last_addr  <= w_ram_addr;
            r_rd_valid   <= 1'b0;
            r_scan_valid <= 1'b0;

            r_tag_vld[0]  <= w_grant_rd | w_grant_scan;
            r_tag_scan[0] <= w_grant_scan;
            r_tag_addr[0] <= r_scan_ptr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_scan[i] <= r_tag_scan[i-1];
                r_tag_addr[i] <= r_tag_addr[i-1];
            end

            if (r_tag_vld[RD_LAT-1]) begin
                if (r_tag_scan[RD_LAT-1]) begin
                    r_scan_data  <= bus.ram_q;
                    r_scan_addr  <= r_tag_addr[RD_LAT-1];
                    r_scan_valid <= 1'b1;
                end else begin
                    r_rd_data  <= bus.ram_q;
                    r_rd_valid <= 1'b1;
                end
            end

            // A tick that lands on an outstanding request is merged and flagged.
            if (bus.tick && (r_scan_pending || w_grant_scan)) begin
                r_scan_ovf <= 1'b1;
            end
            r_scan_pending <= (r_scan_pending | bus.tick) & ~w_grant_scan;

            if (w_grant_scan) begin
                r_scan_ptr <= r_scan_ptr + 1'b1;
                if (r_scan_ptr == LAST_ADDR) begin
                    r_scan_wrap <= ~r_scan_wrap;
                end
            end

            if (r_state == StInit) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
                if (r_fill_cnt == LAST_ADDR) begin
                    r_state <= StRun;
                end
            end

            // Clear overrides everything above: restart the fill, drop in-flight reads.
            if (bus.clear_req) begin
                r_state      <= StInit;
                r_fill_cnt   <= '0;
                r_scan_ptr   <= '0;
                r_scan_ovf   <= 1'b0;
                r_scan_wrap  <= 1'b0;
                r_tag_vld    <= '0;
                r_rd_valid   <= 1'b0;
                r_scan_valid <= 1'b0;
            end
        end
    end

    assign bus.wr_ack     = w_grant_wr;
    assign bus.rd_ack     = w_grant_rd;
    assign bus.ram_addr   = w_ram_addr;
    assign bus.ram_data   = w_ram_data;
    assign bus.ram_wren   = w_ram_wren;
    assign bus.busy       = (r_state == StInit);
    assign bus.rd_data    = r_rd_data;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.scan_addr  = r_scan_addr;
    assign bus.scan_data  = r_scan_data;
    assign bus.scan_valid = r_scan_valid;
    assign bus.scan_wrap  = r_scan_wrap;
    assign bus.scan_ovf   = r_scan_ovf;
endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter: directed bench for ram_access_arbiter with a behavioural
// 1-cycle RAM, a shadow memory and scoreboard queues for user and scan read results.
module tb_ram_access_arbiter;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 32;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    int wr_ack_cnt = 0;
    int rd_ack_cnt = 0;
    int rd_valid_cnt = 0;
    int scan_valid_cnt = 0;

    logic [3:0] shadow [DEPTH];
    logic [3:0] ram_mem [DEPTH] = '{default: 4'hF};
    logic [3:0] rd_q [$];
    logic [8:0] scan_q [$];
    logic [3:0] mon_rd_exp;
    logic [8:0] mon_scan_exp;
    int exp_scan_ptr;
    int base_wr, base_rd, base_rdv, base_scv;
    logic wrap_before;

    ram_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_access_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    // Behavioural single-port RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (bus.ram_wren) ram_mem[bus.ram_addr] <= bus.ram_data;
        bus.ram_q <= ram_mem[bus.ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: pop and compare whenever a result comes out.
    always @(negedge clk) begin
        if (bus.wr_ack === 1'b1) wr_ack_cnt++;
        if (bus.rd_ack === 1'b1) rd_ack_cnt++;
        if (bus.rd_valid === 1'b1) begin
            rd_valid_cnt++;
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 32'(bus.rd_valid), 32'd0);
            end else begin
                mon_rd_exp = rd_q.pop_front();
                check("rd_data", 32'(bus.rd_data), 32'(mon_rd_exp));
            end
        end
        if (bus.scan_valid === 1'b1) begin
            scan_valid_cnt++;
            if (scan_q.size() == 0) begin
                check("scan_unexpected", 32'(bus.scan_valid), 32'd0);
            end else begin
                mon_scan_exp = scan_q.pop_front();
                check("scan_addr", 32'(bus.scan_addr), 32'(mon_scan_exp[8:4]));
                check("scan_data", 32'(bus.scan_data), 32'(mon_scan_exp[3:0]));
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.tick = 1'b0; bus.clear_req = 1'b0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = 4'h0;
        exp_scan_ptr = 0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({bus.rd_valid, bus.scan_valid, bus.wr_ack, bus.rd_ack,
              bus.scan_ovf, bus.scan_wrap, bus.rd_data, bus.scan_data, bus.scan_addr}), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.wr_req = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 4'h6;
        bus.rd_req = 1'b1; bus.rd_addr = 5'd7;

        // Zero-fill sweep with requests held pending
        for (int c = 0; c < DEPTH; c++) begin
            @(negedge clk);
            check($sformatf("init_%0d", c),
                  32'({bus.busy, bus.ram_wren, bus.ram_addr, bus.ram_data, bus.wr_ack, bus.rd_ack}),
                  32'({1'b1, 1'b1, 5'(c), 4'h0, 1'b0, 1'b0}));
        end
        @(negedge clk);
        check("run_write", 32'({bus.busy, bus.ram_wren, bus.ram_addr, bus.ram_data, bus.wr_ack,
              bus.rd_ack}), 32'({1'b0, 1'b1, 5'd9, 4'h6, 1'b1, 1'b0}));
        shadow[9] = 4'h6;
        @(posedge clk); #1;
        bus.wr_req = 1'b0;
        @(negedge clk);
        check("run_read7", 32'({bus.ram_wren, bus.ram_addr, bus.wr_ack, bus.rd_ack}),
              32'({1'b0, 5'd7, 1'b0, 1'b1}));
        rd_q.push_back(shadow[7]);
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Write 0xA to 5, read it back the next cycle
        bus.wr_req = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 4'hA;
        @(negedge clk);
        check("wr5_ack", 32'({bus.wr_ack, bus.ram_wren, bus.ram_addr, bus.ram_data}),
              32'({1'b1, 1'b1, 5'd5, 4'hA}));
        shadow[5] = 4'hA;
        @(posedge clk); #1;
        bus.wr_req = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 5'd5;
        @(negedge clk);
        check("rd5_ack", 32'({bus.rd_ack, bus.wr_ack, bus.ram_wren, bus.ram_addr}),
              32'({1'b1, 1'b0, 1'b0, 5'd5}));
        rd_q.push_back(shadow[5]);
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
        @(negedge clk);
        check("rd5_not_yet", 32'(bus.rd_valid), 32'd0);
        @(negedge clk);
        check("rd5_valid", 32'({bus.rd_valid, bus.rd_data}), 32'({1'b1, 4'hA}));
        repeat (3) @(posedge clk);
        #1;

        // Simultaneous write, read and tick
        base_wr = wr_ack_cnt; base_rd = rd_ack_cnt;
        bus.wr_req = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 4'h3;
        bus.rd_req = 1'b1; bus.rd_addr = 5'd0; bus.tick = 1'b1;
        @(negedge clk);
        check("prio_write", 32'({bus.wr_ack, bus.rd_ack, bus.ram_wren, bus.ram_addr}),
              32'({1'b1, 1'b0, 1'b1, 5'd0}));
        shadow[0] = 4'h3;
        @(posedge clk); #1;
        bus.wr_req = 1'b0; bus.tick = 1'b0;
        @(negedge clk);
        check("prio_read", 32'({bus.wr_ack, bus.rd_ack, bus.ram_wren, bus.ram_addr}),
              32'({1'b0, 1'b1, 1'b0, 5'd0}));
        rd_q.push_back(shadow[0]);
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
        @(negedge clk);
        check("prio_scan", 32'({bus.wr_ack, bus.rd_ack, bus.ram_wren, bus.ram_addr}),
              32'({1'b0, 1'b0, 1'b0, 5'd0}));
        scan_q.push_back({5'(exp_scan_ptr), shadow[exp_scan_ptr]});
        exp_scan_ptr = (exp_scan_ptr + 1) % DEPTH;
        @(negedge clk);
        check("prio_rd_ret", 32'({bus.rd_valid, bus.scan_valid}), 32'({1'b1, 1'b0}));
        @(negedge clk);
        check("prio_scan_ret", 32'({bus.rd_valid, bus.scan_valid}), 32'({1'b0, 1'b1}));
        repeat (3) @(posedge clk);
        check("prio_wr_once", 32'(wr_ack_cnt - base_wr), 32'd1);
        check("prio_rd_once", 32'(rd_ack_cnt - base_rd), 32'd1);
        #1;

        // 32 spaced ticks: full scan sweep
        wrap_before = bus.scan_wrap;
        base_scv = scan_valid_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            bus.tick = 1'b1;
            scan_q.push_back({5'(exp_scan_ptr), shadow[exp_scan_ptr]});
            exp_scan_ptr = (exp_scan_ptr + 1) % DEPTH;
            @(posedge clk); #1;
            bus.tick = 1'b0;
            repeat (7) @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("sweep_count", 32'(scan_valid_cnt - base_scv), 32'd32);
        check("sweep_wrap_once", 32'(bus.scan_wrap ^ wrap_before), 32'd1);
        check("sweep_no_ovf", 32'(bus.scan_ovf), 32'd0);
        @(posedge clk); #1;

        // Starved scan: write held 10 cycles, 2 ticks merge into one read
        base_scv = scan_valid_cnt;
        bus.wr_req = 1'b1; bus.wr_addr = 5'd1; bus.wr_data = 4'h7;
        shadow[1] = 4'h7;
        for (int c = 0; c < 10; c++) begin
            bus.tick = (c == 2 || c == 5);
            @(posedge clk); #1;
        end
        bus.wr_req = 1'b0; bus.tick = 1'b0;
        scan_q.push_back({5'(exp_scan_ptr), shadow[exp_scan_ptr]});
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("starve_ovf", 32'(bus.scan_ovf), 32'd1);
        check("starve_one_scan", 32'(scan_valid_cnt - base_scv), 32'd1);

        // Clear with a scan read in flight
        @(posedge clk); #1;
        base_scv = scan_valid_cnt;
        bus.tick = 1'b1;
        @(posedge clk); #1;
        bus.tick = 1'b0;
        @(posedge clk); #1;
        bus.clear_req = 1'b1;
        @(posedge clk); #1;
        bus.clear_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = 4'h0;
        exp_scan_ptr = 0;
        for (int c = 0; c < DEPTH; c++) begin
            @(negedge clk);
            check($sformatf("clear_fill_%0d", c),
                  32'({bus.busy, bus.ram_wren, bus.ram_addr, bus.ram_data}),
                  32'({1'b1, 1'b1, 5'(c), 4'h0}));
        end
        @(negedge clk);
        check("clear_done", 32'({bus.busy, bus.scan_ovf, bus.scan_wrap}), 32'd0);
        check("clear_flushed", 32'(scan_valid_cnt - base_scv), 32'd0);
        @(posedge clk); #1;
        bus.rd_req = 1'b1; bus.rd_addr = 5'd1;
        @(negedge clk);
        check("clear_rd_ack", 32'(bus.rd_ack), 32'd1);
        rd_q.push_back(shadow[1]);
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Reset with a user read in flight
        base_rdv = rd_valid_cnt;
        bus.rd_req = 1'b1; bus.rd_addr = 5'd5;
        @(negedge clk);
        check("rst_rd_ack", 32'(bus.rd_ack), 32'd1);
        @(posedge clk); #1;
        bus.rd_req = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_reinit", 32'({bus.busy, bus.ram_wren, bus.ram_addr, bus.rd_valid}),
              32'({1'b1, 1'b1, 5'd0, 1'b0}));
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("rst_no_rd_valid", 32'(rd_valid_cnt - base_rdv), 32'd0);
        check("rst_run_again", 32'(bus.busy), 32'd0);
        check("queues_drained", 32'(rd_q.size() + scan_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
